trial_sequencer: RTL and testbench
==================================

Name: trial_sequencer

Overview:
Controller that sequences the movement block through a learning session: it issues the trial index, the per-trial restart (break), the active window and single-cycle change_InVec pulses. Each trial runs until the network reports a goal, or until a step limit is reached. Sits between the top-level session control and movement, taking decisions from the output layer's winner logic.

Parameters:
N_TRIALS, 10'd100, trials per session (1..1023)
MAX_STEPS, 8'd16, moves allowed per trial before timeout
SETTLE_CYCLES, 8'd32, clocks the network integrates after each InVec change before a decision is accepted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; session begins when high in IDLE
dec_valid  in  1  network decision strobe, one cycle
dec_move  in  1  with dec_valid: 1 = move (swap position), 0 = stay
goal  in  1  with dec_valid: current position is rewarded
iTrial  out  10  current trial index, to movement and StartPoint
active  out  1  high while a trial is in progress
break_o  out  1  restart pulse to movement (reloads the start point)
change_InVec  out  1  one-cycle move pulse to movement
step_cnt  out  8  moves taken in the current trial
trial_done  out  1  one-cycle pulse at trial end
timeout  out  1  valid with trial_done: trial ended on MAX_STEPS
session_done  out  1  level; all trials complete

Behaviour:
- Reset is asynchronous. On assertion all outputs are 0, the counters are cleared and the state is IDLE. Reset mid-trial aborts the trial with no trial_done.
- States: IDLE, INIT, SETTLE, WAIT_DEC, MOVE, END, DONE.
- IDLE: when start=1, go to INIT next clock. iTrial stays 0.
- INIT (1 cycle): break_o=1, active=0, step_cnt<=0, settle counter<=0. Next state is SETTLE.
- SETTLE: active=1. The counter counts SETTLE_CYCLES clocks. Any dec_valid seen here is ignored and dropped. When the count is reached, go to WAIT_DEC.
- WAIT_DEC: active=1 and waits with no limit.
  - dec_valid & goal: go to END with timeout=0. Goal has priority over dec_move.
  - dec_valid & ~goal & dec_move: go to MOVE.
  - dec_valid & ~goal & ~dec_move: stay in place. Restart SETTLE with no step counted.
- MOVE (1 cycle): change_InVec=1 and step_cnt<=step_cnt+1.
  - If the new step_cnt equals MAX_STEPS, go to END with timeout=1.
  - Otherwise go to SETTLE with the counter cleared.
- END (1 cycle): trial_done=1, timeout as set, active=0.
  - If iTrial==N_TRIALS-1, go to DONE.
  - Otherwise iTrial<=iTrial+1 and go to INIT.
- DONE: session_done=1 and all other outputs are 0. iTrial holds its final value. Leaves only on reset. start is ignored.
- break_o and change_InVec are never high in the same cycle. This respects movement's priority, where change_InVec overrides break.
- Output timing:
  - All outputs are registered, so they change one clock after the state transition that produces them.
  - Decision-to-change_InVec latency is exactly 1 clock from the dec_valid edge.
- Widths:
  - step_cnt saturates at MAX_STEPS and never wraps.
  - iTrial never exceeds N_TRIALS-1.
- start may drop after leaving IDLE with no effect.

Decomposition:
- Shared package Net_parameters: state encoding localparams (3-bit), plus the default values of MAX_STEPS and SETTLE_CYCLES alongside Neurons_Layer1.
- One natural sub-module, settle_timer: a loadable down-counter with a clear input and a done output, reused by SETTLE.
- The FSM, trial counter and step counter stay in trial_sequencer.

Test Plan:
- Reset/idle: assert reset mid-SETTLE of trial 3 -> all outputs 0 at once, iTrial=0. Release with start=0 -> stays IDLE and active=0.
- Goal on first decision: N_TRIALS=2, SETTLE_CYCLES=4, start=1. dec_valid&goal at the first WAIT_DEC:
  - break_o pulses once.
  - trial_done pulses with timeout=0 and step_cnt=0.
  - iTrial then reads 1.
- Move path: dec_valid&dec_move&~goal, three times, then a goal decision:
  - exactly 3 change_InVec pulses, each 1 clock after its dec_valid;
  - step_cnt=3 at trial_done.
- Stay: dec_valid&~dec_move&~goal -> no change_InVec, step_cnt unchanged, a fresh 4-cycle SETTLE before the next decision is accepted.
- Timeout: MAX_STEPS=2, only move decisions -> second change_InVec then trial_done with timeout=1 and step_cnt=2. The next trial starts with a break_o pulse.
- Session end and ignored decisions:
  - After the last trial, session_done=1 and iTrial=N_TRIALS-1.
  - Further start/dec_valid have no effect.
  - dec_valid during SETTLE never produces change_InVec.

Source files
------------

// File: rtl/Net_parameters.sv
// Shared constants for the learning-session controller: state encoding,
// default trial timing and network dimensions.
package Net_parameters;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INIT     = 3'd1;
    localparam logic [2:0] ST_SETTLE   = 3'd2;
    localparam logic [2:0] ST_WAIT_DEC = 3'd3;
    localparam logic [2:0] ST_MOVE     = 3'd4;
    localparam logic [2:0] ST_END      = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_INIT     = ST_INIT,
        S_SETTLE   = ST_SETTLE,
        S_WAIT_DEC = ST_WAIT_DEC,
        S_MOVE     = ST_MOVE,
        S_END      = ST_END,
        S_DONE     = ST_DONE
    } state_t;

    localparam logic [7:0] MAX_STEPS_DEFAULT     = 8'd16;
    localparam logic [7:0] SETTLE_CYCLES_DEFAULT = 8'd32;
    localparam int         Neurons_Layer1        = 16;

    // The timer counts down to zero inclusive, so it is loaded one short.
    function automatic logic [7:0] settle_load(input logic [7:0] cycles);
        return (cycles == 8'd0) ? 8'd0 : cycles - 8'd1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; o_done is high whenever the count has reached zero.
module settle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [7:0] i_value,
    input  logic       i_en,
    output logic       o_done
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_done = (r_count == 8'd0);

endmodule

// File: rtl/trial_sequencer.sv
// Steps the movement block through a session of trials, each ending on a goal
// decision or after MAX_STEPS moves. All outputs are registered.
module trial_sequencer
    import Net_parameters::*;
#(
    parameter logic [9:0] N_TRIALS      = 10'd100,
    parameter logic [7:0] MAX_STEPS     = MAX_STEPS_DEFAULT,
    parameter logic [7:0] SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dec_valid,
    input  logic       dec_move,
    input  logic       goal,
    output logic [9:0] iTrial,
    output logic       active,
    output logic       break_o,
    output logic       change_InVec,
    output logic [7:0] step_cnt,
    output logic       trial_done,
    output logic       timeout,
    output logic       session_done,
    output state_t     dbg_state
);

    state_t     r_state;
    logic [9:0] r_itrial;
    logic [7:0] r_step;
    logic       r_active;
    logic       r_break;
    logic       r_change;
    logic       r_done;
    logic       r_timeout;
    logic       r_session;

    logic w_at_max;
    logic w_last_trial;
    logic w_stay;
    logic w_timer_load;
    logic w_timer_clear;
    logic w_settle_done;

    assign w_at_max     = (r_step == MAX_STEPS);
    assign w_last_trial = (r_itrial == (N_TRIALS - 10'd1));
    assign w_stay       = (r_state == S_WAIT_DEC) && dec_valid && !goal && !dec_move;

    // Every entry into SETTLE reloads the timer for a full integration window.
    assign w_timer_load  = (r_state == S_INIT) || w_stay || ((r_state == S_MOVE) && !w_at_max);
    assign w_timer_clear = (r_state == S_IDLE) || (r_state == S_END) || (r_state == S_DONE);

    settle_timer u_settle_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_timer_clear),
        .i_load  (w_timer_load),
        .i_value (settle_load(SETTLE_CYCLES)),
        .i_en    (r_state == S_SETTLE),
        .o_done  (w_settle_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_itrial  <= 10'd0;
            r_step    <= 8'd0;
            r_active  <= 1'b0;
            r_break   <= 1'b0;
            r_change  <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_session <= 1'b0;
        end else begin
            r_break   <= 1'b0;
            r_change  <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_INIT;
                        r_break <= 1'b1;
                        r_step  <= 8'd0;
                    end
                end
                S_INIT: begin
                    r_state  <= S_SETTLE;
                    r_active <= 1'b1;
                end
                S_SETTLE: begin
                    if (w_settle_done) begin
                        r_state <= S_WAIT_DEC;
                    end
                end
                S_WAIT_DEC: begin
                    if (dec_valid) begin
                        if (goal) begin
                            r_state  <= S_END;
                            r_done   <= 1'b1;
                            r_active <= 1'b0;
                        end else if (dec_move) begin
                            r_state  <= S_MOVE;
                            r_change <= 1'b1;
                            if (!w_at_max) begin
                                r_step <= r_step + 8'd1;
                            end
                        end else begin
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_MOVE: begin
                    if (w_at_max) begin
                        r_state   <= S_END;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_active  <= 1'b0;
                    end else begin
                        r_state <= S_SETTLE;
                    end
                end
                S_END: begin
                    r_step <= 8'd0;
                    if (w_last_trial) begin
                        r_state   <= S_DONE;
                        r_session <= 1'b1;
                    end else begin
                        r_state  <= S_INIT;
                        r_itrial <= r_itrial + 10'd1;
                        r_break  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign iTrial       = r_itrial;
    assign active       = r_active;
    assign break_o      = r_break;
    assign change_InVec = r_change;
    assign step_cnt     = r_step;
    assign trial_done   = r_done;
    assign timeout      = r_timeout;
    assign session_done = r_session;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_trial_sequencer.sv
// Randomized session driver with a cycle-accurate event model; a negedge
// monitor pops predicted break/change/done events and compares them.
module tb_trial_sequencer;
    import Net_parameters::*;

    localparam int NT = 6;
    localparam int MX = 4;
    localparam int S  = 4;
    localparam int W  = 54;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dec_valid;
    logic       dec_move;
    logic       goal;
    logic [9:0] iTrial;
    logic       active;
    logic       break_o;
    logic       change_InVec;
    logic [7:0] step_cnt;
    logic       trial_done;
    logic       timeout;
    logic       session_done;
    state_t     dbg_state;

    trial_sequencer #(
        .N_TRIALS      (10'(NT)),
        .MAX_STEPS     (8'(MX)),
        .SETTLE_CYCLES (8'(S))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dec_valid    (dec_valid),
        .dec_move     (dec_move),
        .goal         (goal),
        .iTrial       (iTrial),
        .active       (active),
        .break_o      (break_o),
        .change_InVec (change_InVec),
        .step_cnt     (step_cnt),
        .trial_done   (trial_done),
        .timeout      (timeout),
        .session_done (session_done),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    int  m_trial;
    int  m_step;
    int  settle_start;
    int  ready;
    bit  session_over;

    function automatic logic [W-1:0] ev(input bit b, input bit ch, input bit d,
                                        input int c, input int tr, input int st, input bit to);
        return {b, ch, d, 32'(c), 10'(tr), 8'(st), to};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Event record: {break, change, done, cycle, iTrial, step_cnt, timeout}
    always @(negedge clk) begin
        if (!reset && (break_o || change_InVec || trial_done)) begin
            check("break_change_exclusive", 64'(break_o & change_InVec), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got b=%0d c=%0d d=%0d at cycle %0d, expected none",
                         break_o, change_InVec, trial_done, cyc);
            end else begin
                check("event", 64'(ev(break_o, change_InVec, trial_done, cyc,
                                     int'(iTrial), int'(step_cnt), timeout)),
                      64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        int c;
        m_trial = 0;
        m_step = 0;
        session_over = 0;
        start = 1'b1;
        c = cyc;
        exp_q.push_back(ev(1, 0, 0, c + 1, 0, 0, 0));
        settle_start = c + 2;
        ready = c + 2 + S;
        tick();
        start = 1'($urandom_range(0, 1));
    endtask

    task automatic end_trial(input int done_cyc, input bit to);
        exp_q.push_back(ev(0, 0, 1, done_cyc, m_trial, m_step, to));
        if (m_trial == NT - 1) begin
            session_over = 1;
        end else begin
            m_trial++;
            m_step = 0;
            exp_q.push_back(ev(1, 0, 0, done_cyc + 1, m_trial, 0, 0));
            settle_start = done_cyc + 2;
            ready = done_cyc + 2 + S;
        end
    endtask

    task automatic decide(input bit mv, input bit gl, input bit noisy);
        int extra;
        int c;
        extra = $urandom_range(0, 2);
        while (cyc < ready + extra) begin
            if (noisy && cyc >= settle_start && cyc < ready) begin
                dec_valid = ($urandom_range(0, 2) == 0);
                dec_move  = 1'($urandom_range(0, 1));
                goal      = 1'($urandom_range(0, 1));
            end else begin
                dec_valid = 1'b0;
            end
            tick();
        end
        check("active_at_decision", 64'(active), 64'd1);
        check("step_at_decision", 64'(step_cnt), 64'(m_step));
        dec_valid = 1'b1;
        dec_move = mv;
        goal = gl;
        c = cyc;
        tick();
        dec_valid = 1'b0;
        dec_move = 1'b0;
        goal = 1'b0;
        if (gl) begin
            end_trial(c + 1, 0);
        end else if (mv) begin
            if (m_step < MX) m_step++;
            exp_q.push_back(ev(0, 1, 0, c + 1, m_trial, m_step, 0));
            if (m_step == MX) begin
                end_trial(c + 2, 1);
            end else begin
                settle_start = c + 2;
                ready = c + 2 + S;
            end
        end else begin
            settle_start = c + 1;
            ready = c + 1 + S;
        end
    endtask

    task automatic early_poke();
        while (cyc < ready - 1) tick();
        dec_valid = 1'b1;
        dec_move = 1'b1;
        goal = 1'b0;
        tick();
        dec_valid = 1'b0;
        dec_move = 1'b0;
    endtask

    task automatic run_random_trial(input bit force_timeout);
        int t0;
        int r;
        t0 = m_trial;
        while (m_trial == t0 && !session_over) begin
            r = $urandom_range(0, 3);
            if (force_timeout) decide(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            else decide(r >= 2, r == 0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_active"}, 64'(active), 64'd0);
        check({tag, "_break"}, 64'(break_o), 64'd0);
        check({tag, "_change"}, 64'(change_InVec), 64'd0);
        check({tag, "_done"}, 64'(trial_done), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_step"}, 64'(step_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: got no finish by cycle %0d, expected end of sequence", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dec_valid = 1'b0;
        dec_move = 1'b0;
        goal = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        check("reset_itrial", 64'(iTrial), 64'd0);
        check("reset_session", 64'(session_done), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(S_IDLE));
        reset = 1'b0;
        repeat (3) tick();
        check_quiet("idle");
        check("idle_itrial", 64'(iTrial), 64'd0);

        // First session: goal-first, three moves, stay with an early poke, then abort.
        start_session();
        decide(1'b0, 1'b1, 1'b0);
        repeat (3) decide(1'b1, 1'b0, 1'b1);
        decide(1'b0, 1'b1, 1'b1);
        decide(1'b0, 1'b0, 1'b0);
        early_poke();
        decide(1'b0, 1'b1, 1'b0);
        while (cyc < settle_start + 1) tick();
        check("trial3_active", 64'(active), 64'd1);
        reset = 1'b1;
        #2;
        check_quiet("abort");
        check("abort_itrial", 64'(iTrial), 64'd0);
        check("abort_session", 64'(session_done), 64'd0);
        check("abort_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        start = 1'b0;
        repeat (4) tick();
        check_quiet("post_abort");
        check("post_abort_state", 64'(dbg_state), 64'(S_IDLE));

        // Second session: randomized trials, trial 1 forced to time out.
        start_session();
        for (int t = 0; t < NT && !session_over; t++) begin
            run_random_trial(t == 1);
        end
        check("session_over_model", 64'(session_over), 64'd1);
        repeat (3) tick();
        check("session_done", 64'(session_done), 64'd1);
        check("final_itrial", 64'(iTrial), 64'(NT - 1));
        check_quiet("done");
        for (int i = 0; i < 20; i++) begin
            start = 1'($urandom_range(0, 1));
            dec_valid = 1'($urandom_range(0, 1));
            dec_move = 1'($urandom_range(0, 1));
            goal = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        dec_valid = 1'b0;
        repeat (2) tick();
        check("done_hold_session", 64'(session_done), 64'd1);
        check("done_hold_itrial", 64'(iTrial), 64'(NT - 1));
        check_quiet("done_hold");
        check("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
